// File: rtl/wave_pkg.sv
// Shared definitions for the waveform counter and its direction controller.
package wave_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'b00,
        MODE_SAW_UP   = 2'b01,
        MODE_SAW_DOWN = 2'b10,
        MODE_TRI      = 2'b11
    } mode_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// Enabled-clock prescaler: one tick every div+1 enabled clocks.
module tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a divisor lowered below the running count fires at once
    assign tick = enable && (cnt >= div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/waveform_counter.sv
// Fixed-point phase accumulator with saw/triangle modes, period marker and end flags.
module waveform_counter
    import wave_pkg::*;
#(
    parameter int W      = 5,
    parameter int F      = 4,
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic [DIV_W-1:0]  div,
    output logic [W-1:0]      count,
    output logic [F-1:0]      fraction,
    output logic              wrap,
    output logic              at_top,
    output logic              at_bottom
);

    localparam int AW = W + F;
    localparam logic [AW-1:0] MAX = '1;

    mode_t          mode_sel;
    logic           tick;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  acc_next;
    logic [AW-1:0]  step_ext;
    logic [AW:0]    sum;
    logic [AW:0]    diff;
    logic           wrap_next;

    assign mode_sel = mode_t'(mode);
    assign step_ext = {{(AW-STEP_W){1'b0}}, step};
    assign sum      = {1'b0, acc} + {1'b0, step_ext};
    assign diff     = {1'b0, acc} - {1'b0, step_ext};

    tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .div    (div),
        .tick   (tick)
    );

    // Extra MSB of sum/diff is the carry/borrow used for the saw wrap marker
    always_comb begin
        acc_next  = acc;
        wrap_next = 1'b0;
        if (mode_sel == MODE_IDLE) begin
            acc_next = '0;
        end else if (tick) begin
            case (mode_sel)
                MODE_SAW_UP: begin
                    acc_next  = sum[AW-1:0];
                    wrap_next = sum[AW];
                end
                MODE_SAW_DOWN: begin
                    acc_next  = diff[AW-1:0];
                    wrap_next = diff[AW];
                end
                MODE_TRI: begin
                    if (up == UP) begin
                        acc_next = sum[AW] ? MAX : sum[AW-1:0];
                    end else begin
                        acc_next  = diff[AW] ? '0 : diff[AW-1:0];
                        wrap_next = (acc != '0) && (acc_next == '0);
                    end
                end
                default: begin
                    acc_next = acc;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            wrap      <= 1'b0;
            at_top    <= 1'b0;
            at_bottom <= 1'b1;
        end else begin
            acc       <= acc_next;
            wrap      <= wrap_next;
            at_top    <= (acc_next == MAX);
            at_bottom <= (acc_next == '0);
        end
    end

    assign count    = acc[AW-1:F];
    assign fraction = acc[F-1:0];

endmodule

// File: tb/tb_waveform_counter.sv
// Directed bench for waveform_counter with small reference models for saw, triangle and prescaler.
module tb_waveform_counter;
    import wave_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic       up;
    logic [7:0] step;
    logic [7:0] div;
    logic [4:0] count;
    logic [3:0] fraction;
    logic       wrap;
    logic       at_top;
    logic       at_bottom;
    logic [8:0] acc_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign acc_o = {count, fraction};

    waveform_counter dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .up        (up),
        .step      (step),
        .div       (div),
        .count     (count),
        .fraction  (fraction),
        .wrap      (wrap),
        .at_top    (at_top),
        .at_bottom (at_bottom)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk_step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  ref_acc;
        int  e_acc;
        int  n_acc;
        bit  e_wrap;
        bit  e_top;
        bit  e_bot;
        bit  old_top;
        bit  old_bot;
        bit  en;
        bit  tck;
        int  pc;

        reset  = 1'b0;
        enable = 1'b0;
        mode   = MODE_IDLE;
        up     = UP;
        step   = 8'h00;
        div    = 8'd0;
        #1 reset = 1'b1;
        #1;
        chk("rst_acc", acc_o, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_top", at_top, 0);
        chk("rst_bottom", at_bottom, 1);

        // reset mid-run with acc=200
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        mode   = MODE_SAW_UP;
        step   = 8'hC8;
        clk_step();
        chk("pre_reset_acc", acc_o, 200);
        #2 reset = 1'b1;
        #1;
        chk("midrst_acc", acc_o, 0);
        chk("midrst_bottom", at_bottom, 1);
        chk("midrst_wrap", wrap, 0);
        @(negedge clk);
        reset = 1'b0;
        step  = 8'h10;

        // saw up, one count per clock, period 32
        for (int k = 1; k <= 32; k++) begin
            clk_step();
            chk("saw_count", count, k % 32);
            chk("saw_frac", fraction, 0);
            chk("saw_wrap", wrap, (k == 32) ? 1 : 0);
        end
        clk_step();
        chk("saw_after_wrap_count", count, 1);
        chk("saw_after_wrap_pulse", wrap, 0);

        // saw up 1.5 per tick against a model, 1000 ticks
        mode = MODE_IDLE;
        clk_step();
        chk("idle_clear", acc_o, 0);
        chk("idle_bottom", at_bottom, 1);
        mode    = MODE_SAW_UP;
        step    = 8'h18;
        ref_acc = 0;
        for (int k = 0; k < 1000; k++) begin
            clk_step();
            ref_acc = ref_acc + 24;
            e_wrap  = (ref_acc >= 512);
            ref_acc = ref_acc % 512;
            chk("saw15_acc", acc_o, ref_acc);
            chk("saw15_wrap", wrap, e_wrap);
        end

        // saw down borrow from acc=2
        mode = MODE_IDLE;
        clk_step();
        mode = MODE_SAW_UP;
        step = 8'h02;
        clk_step();
        chk("down_setup", acc_o, 2);
        mode = MODE_SAW_DOWN;
        step = 8'h30;
        clk_step();
        chk("down_count", count, 29);
        chk("down_frac", fraction, 2);
        chk("down_wrap", wrap, 1);
        clk_step();
        chk("down_next_acc", acc_o, 418);
        chk("down_next_wrap", wrap, 0);

        // triangle with a registered direction controller model
        mode = MODE_IDLE;
        clk_step();
        up    = UP;
        mode  = MODE_TRI;
        step  = 8'h10;
        e_acc = 0;
        e_top = 1'b0;
        e_bot = 1'b1;
        for (int k = 0; k < 100; k++) begin
            clk_step();
            old_top = e_top;
            old_bot = e_bot;
            if (up) begin
                n_acc  = (e_acc + 16 > 511) ? 511 : e_acc + 16;
                e_wrap = 1'b0;
            end else begin
                n_acc  = (16 > e_acc) ? 0 : e_acc - 16;
                e_wrap = (e_acc != 0) && (n_acc == 0);
            end
            e_acc = n_acc;
            e_top = (e_acc == 511);
            e_bot = (e_acc == 0);
            chk("tri_acc", acc_o, e_acc);
            chk("tri_wrap", wrap, e_wrap);
            chk("tri_top", at_top, e_top);
            chk("tri_bottom", at_bottom, e_bot);
            if (old_top)
                up = DOWN;
            else if (old_bot)
                up = UP;
        end

        // div=3 with an enable gap of 5 clocks
        mode = MODE_IDLE;
        div  = 8'd0;
        clk_step();
        mode  = MODE_SAW_UP;
        step  = 8'h10;
        div   = 8'd3;
        e_acc = 0;
        pc    = 0;
        for (int c = 0; c < 30; c++) begin
            en     = !(c >= 10 && c < 15);
            enable = en;
            clk_step();
            tck    = en && (pc >= 3);
            e_wrap = 1'b0;
            if (tck) begin
                e_wrap = (e_acc + 16 >= 512);
                e_acc  = (e_acc + 16) % 512;
                pc     = 0;
            end else if (en) begin
                pc = pc + 1;
            end
            chk("div3_acc", acc_o, e_acc);
            chk("div3_wrap", wrap, e_wrap);
        end
        enable = 1'b1;

        // divisor lowered below a running prescaler
        mode = MODE_IDLE;
        div  = 8'd0;
        clk_step();
        mode = MODE_SAW_UP;
        step = 8'h10;
        div  = 8'd200;
        repeat (150) clk_step();
        chk("div200_hold", acc_o, 0);
        div = 8'd2;
        clk_step();
        chk("forced_tick_acc", acc_o, 16);
        clk_step();
        chk("after_forced_acc", acc_o, 16);
        clk_step();
        chk("div2_wait_acc", acc_o, 16);
        clk_step();
        chk("div2_tick_acc", acc_o, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
